alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 20 ++
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, default ALU latency and FSM state encoding for alu_arbiter
package alu_pkg;
  localparam int OPCODE_SIZE = 3;
  localparam int DATA_SIZE = 8;
  localparam int ALU_LATENCY_DEF = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant (lowest index at or after ptr wins) and next-pointer; ports req/ptr in, gnt/idx/ptr_nx out
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic [$clog2(NUM_REQ)-1:0] ptr_nx
);
  localparam int IW = $clog2(NUM_REQ);
  always_comb begin
    idx = '0;
    // scan from farthest to nearest so the closest request at/after ptr is assigned last
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = IW'((int'(ptr) + k) % NUM_REQ);
    gnt = |req ? {{(NUM_REQ-1){1'b0}}, 1'b1} << idx : '0;
    ptr_nx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU among NUM_REQ requesters; ports clk/rst_n, req_* (valid/ready/func/data1/data2), resp_* (valid/ready/id/data), alu_* to/from the ALU, busy; grant_count only with ALU_ARB_STATS_EN
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int opcodeSize = OPCODE_SIZE,
  parameter int dataSize = DATA_SIZE,
  parameter int ALU_LATENCY = ALU_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*opcodeSize-1:0] req_func,
  input  logic [NUM_REQ*dataSize-1:0]   req_data1,
  input  logic [NUM_REQ*dataSize-1:0]   req_data2,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [dataSize-1:0]           resp_data,
  output logic [opcodeSize-1:0]         alu_func,
  output logic [dataSize-1:0]           alu_data1,
  output logic [dataSize-1:0]           alu_data2,
  input  logic [dataSize-1:0]           alu_dataOut,
  output logic                          busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nx;
  logic [IW-1:0] ptr, gidx, ptr_nx;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0] cnt;
  logic accept, wait_last;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .ptr_nx(ptr_nx)
  );
  // rst_n gates accept so req_ready stays low while reset is held
  assign accept = rst_n && state == IDLE && |req_valid;
  assign wait_last = state == WAIT && cnt == 3'(ALU_LATENCY);
  assign req_ready = accept ? gnt : '0;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? WAIT : IDLE;
      WAIT: state_nx = wait_last ? RESP : WAIT;
      RESP: state_nx = resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      resp_id <= '0;
      resp_data <= '0;
      alu_func <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ptr <= ptr_nx;
        cnt <= '0;
        resp_id <= gidx;
        alu_func <= req_func[gidx*opcodeSize +: opcodeSize];
        alu_data1 <= req_data1[gidx*dataSize +: dataSize];
        alu_data2 <= req_data2[gidx*dataSize +: dataSize];
      end
      if (state == WAIT) cnt <= cnt + 3'd1;
      if (wait_last) resp_data <= alu_dataOut;
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_count <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (accept && gnt[i] && grant_count[i*16 +: 16] != 16'hFFFF)
          grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level reference model
module tb_alu_arbiter;
  localparam int N = 4, OW = 3, DW = 8, L = 1, IW = 2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready;
  logic [N*OW-1:0] req_func;
  logic [N*DW-1:0] req_data1, req_data2;
  logic resp_valid, resp_ready, busy;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_data, alu_data1, alu_data2, alu_dataOut;
  logic [OW-1:0] alu_func;
`ifdef ALU_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif
  alu_arbiter #(.NUM_REQ(N), .opcodeSize(OW), .dataSize(DW), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_data1(req_data1), .req_data2(req_data2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .alu_func(alu_func), .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_dataOut(alu_dataOut),
    .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );
  function automatic logic [DW-1:0] alu_op(logic [OW-1:0] f, logic [DW-1:0] a, logic [DW-1:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << 1;
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction
  logic [DW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= alu_op(alu_func, alu_data1, alu_data2);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign alu_dataOut = pipe[L-1];
  int checks = 0, errors = 0, cyc = 0, ptr = 0, t_acc = 0, exp_id = 0;
  bit rv [N];
  logic [OW-1:0] rf [N];
  logic [DW-1:0] ra [N], rb [N];
  bit have = 0, refill = 0;
  logic [OW-1:0] e_f;
  logic [DW-1:0] e_a, e_b, exp_data;
  int grants [$];
  int gc [N];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic new_op(int i);
    rv[i] = 1;
    rf[i] = OW'($urandom);
    ra[i] = DW'($urandom);
    rb[i] = DW'($urandom);
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rv[i];
      req_func[i*OW +: OW] = rf[i];
      req_data1[i*DW +: DW] = ra[i];
      req_data2[i*DW +: DW] = rb[i];
    end
  endtask
  task automatic step();
    drive();
    #1;
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("grant_count", grant_count[i*16 +: 16], gc[i]);
`endif
    if (!have) begin
      int g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && rv[(ptr + k) % N]) g = (ptr + k) % N;
      check("req_ready", req_ready, g < 0 ? 0 : (1 << g));
      check("busy_idle", busy, 0);
      check("resp_valid_idle", resp_valid, 0);
      if (g >= 0) begin
        have = 1; t_acc = cyc; exp_id = g;
        e_f = rf[g]; e_a = ra[g]; e_b = rb[g];
        exp_data = alu_op(rf[g], ra[g], rb[g]);
        ptr = (g + 1) % N;
        grants.push_back(g);
        if (gc[g] < 65535) gc[g]++;
        if (refill) new_op(g); else rv[g] = 0;
      end
    end else begin
      bit ev = cyc >= t_acc + L + 2;
      check("req_ready_busy", req_ready, 0);
      check("busy", busy, 1);
      check("resp_valid", resp_valid, ev);
      check("alu_func", alu_func, e_f);
      check("alu_data1", alu_data1, e_a);
      check("alu_data2", alu_data2, e_b);
      if (ev) begin
        check("resp_id", resp_id, exp_id);
        check("resp_data", resp_data, exp_data);
        if (resp_ready) have = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk_zero(string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rvalid"}, resp_valid, 0);
    check({tag, "_rid"}, resp_id, 0);
    check({tag, "_rdata"}, resp_data, 0);
    check({tag, "_func"}, alu_func, 0);
    check({tag, "_d1"}, alu_data1, 0);
    check({tag, "_d2"}, alu_data2, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef ALU_ARB_STATS_EN
    check({tag, "_gcnt"}, grant_count, 0);
`endif
  endtask
  task automatic do_reset(logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i]) new_op(i); else rv[i] = 0;
    rst_n = 0;
    drive();
    #1;
    chk_zero("rst");
    have = 0; ptr = 0; grants.delete();
    for (int i = 0; i < N; i++) gc[i] = 0;
    @(posedge clk);
    #1;
    cyc++;
    chk_zero("rst_hold");
    rst_n = 1;
  endtask
  task automatic run_until_idle();
    int n = 0;
    step();
    while (have && n < 50) begin
      step();
      n++;
    end
    if (have) check("timeout", 1, 0);
  endtask
  initial begin
    resp_ready = 1;
    for (int i = 0; i < N; i++) begin
      rv[i] = 0; rf[i] = '0; ra[i] = '0; rb[i] = '0;
    end
    drive();
    @(posedge clk);
    #1;
    do_reset('0);
    rv[0] = 1; rf[0] = 3'b000; ra[0] = 8'd1; rb[0] = 8'd2;
    repeat (4) step();
    check("single_id", resp_id, 0);
    check("single_data", resp_data, 3);
    check("single_done", have, 0);
    do_reset('0);
    refill = 1;
    for (int i = 0; i < N; i++) new_op(i);
    for (int n = 0; n < 100 && grants.size() < 5; n++) step();
    check("rr_count", grants.size(), 5);
    for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", grants[k], k % N);
    refill = 0;
    for (int i = 0; i < N; i++) rv[i] = 0;
    run_until_idle();
    new_op(2);
    new_op(0);
    resp_ready = 0;
    step();
    for (int n = 0; n < 20 && cyc < t_acc + L + 2; n++) step();
    repeat (5) step();
    check("hold_grants", grants.size(), 6);
    resp_ready = 1;
    run_until_idle();
    run_until_idle();
    do_reset('0);
    new_op(3);
    run_until_idle();
    check("wrap_a", grants[grants.size()-1], 3);
    new_op(0);
    new_op(3);
    run_until_idle();
    check("wrap_b", grants[grants.size()-1], 0);
    run_until_idle();
    check("wrap_c", grants[grants.size()-1], 3);
    new_op(1);
    step();
    step();
    do_reset(4'b0110);
    step();
    check("post_rst_grant", grants.size() > 0 ? grants[grants.size()-1] : -1, 1);
    run_until_idle();
    run_until_idle();
    do_reset('0);
    repeat (3) begin
      new_op(2);
      run_until_idle();
    end
    step();
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stats_slice", grant_count[i*16 +: 16], i == 2 ? 3 : 0);
`endif
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) if (!rv[i] && $urandom_range(2) == 0) new_op(i);
      resp_ready = $urandom_range(1);
      step();
    end
    resp_ready = 1;
    for (int i = 0; i < N; i++) rv[i] = 0;
    run_until_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
